// File: rtl/issue_queue.sv
// issue_queue: circular-buffer FIFO between an upstream arbiter and a
// downstream consumer. Registered pointers and occupancy counter; the head
// word is presented one cycle after it is written (no bypass path).
module issue_queue #(
    parameter int unsigned SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int unsigned QUEUE_DEPTH                  = 8,
    localparam int unsigned QUEUE_PTR_WIDTH             = $clog2(QUEUE_DEPTH)
) (
    input  logic                                    clk_in,
    input  logic                                    reset_in,
    input  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_in,
    input  logic                                    request_valid_in,
    output logic                                    issue_ack_out,
    output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_out,
    output logic                                    request_valid_out,
    input  logic                                    issue_ack_in,
    output logic [QUEUE_PTR_WIDTH:0]                entry_count_out,
    output logic                                    full_out,
    output logic                                    empty_out
);

    localparam logic [QUEUE_PTR_WIDTH:0] DEPTH_COUNT = (QUEUE_PTR_WIDTH + 1)'(QUEUE_DEPTH);

    logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0] mem_q [QUEUE_DEPTH];
    logic [QUEUE_PTR_WIDTH-1:0]              wr_ptr_q, wr_ptr_d;
    logic [QUEUE_PTR_WIDTH-1:0]              rd_ptr_q, rd_ptr_d;
    logic [QUEUE_PTR_WIDTH:0]                count_q,  count_d;
    logic                                    push, pop;

    // Status flags, handshakes and head-of-queue output
    always_comb begin
        empty_out         = (count_q == '0);
        full_out          = (count_q == DEPTH_COUNT);
        // Accept is withheld while full even if a pop happens this cycle,
        // and forced low while reset is asserted.
        issue_ack_out     = request_valid_in & ~full_out & reset_in;
        request_valid_out = ~empty_out;
        request_out       = empty_out ? '0 : mem_q[rd_ptr_q];
        entry_count_out   = count_q;
        push              = request_valid_in & issue_ack_out;
        pop               = issue_ack_in & request_valid_out;
    end

    // Next-state for pointers and occupancy counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and counter registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are not cleared by reset
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= request_in;
        end
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter SINGLE_REQUEST_WIDTH_IN_BITS, default 64, width of one request word.
REQ-002 Parameter QUEUE_DEPTH, default 8, number of entries; power of two, >= 2.
REQ-003 Derived QUEUE_PTR_WIDTH = $clog2(QUEUE_DEPTH); count width = QUEUE_PTR_WIDTH + 1.
REQ-004 clk_in  input  1  single clock; all state updates on rising edge.
REQ-005 reset_in  input  1  synchronous, active-low reset (reset asserted when reset_in = 0, sampled on clk_in rising edge).
REQ-006 request_in  input  SINGLE_REQUEST_WIDTH_IN_BITS  upstream request word (arbiter output).
REQ-007 request_valid_in  input  1  upstream request word valid.
REQ-008 issue_ack_out  output  1  accept strobe to upstream; request taken in any cycle where request_valid_in & issue_ack_out at the clock edge.
REQ-009 request_out  output  SINGLE_REQUEST_WIDTH_IN_BITS  head-of-queue word to downstream.
REQ-010 request_valid_out  output  1  head-of-queue valid.
REQ-011 issue_ack_in  input  1  downstream accept; head popped when issue_ack_in & request_valid_out at the clock edge.
REQ-012 entry_count_out  output  QUEUE_PTR_WIDTH+1  number of occupied entries.
REQ-013 full_out  output  1  entry_count_out == QUEUE_DEPTH.
REQ-014 empty_out  output  1  entry_count_out == 0.

Function
REQ-015 Storage SHALL be a QUEUE_DEPTH-entry circular buffer with write pointer, read pointer and occupancy counter, all registered.
REQ-016 issue_ack_out SHALL be combinational: request_valid_in & ~full_out; no ack while full, even if a pop occurs the same cycle.
REQ-017 Push: on edge with request_valid_in & issue_ack_out, request_in written at write pointer; write pointer +1 modulo QUEUE_DEPTH.
REQ-018 Pop: on edge with issue_ack_in & request_valid_out, read pointer +1 modulo QUEUE_DEPTH.
REQ-019 Counter: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or neither.
REQ-020 Pointer wrap SHALL occur from QUEUE_DEPTH-1 to 0 with no lost or duplicated entry.
REQ-021 request_valid_out SHALL equal ~empty_out; request_out SHALL be the entry at read pointer when non-empty, all-zero when empty.
REQ-022 Latency: word pushed into an empty queue at edge t SHALL appear on request_out/request_valid_out after edge t; no same-cycle bypass.
REQ-023 Order SHALL be strictly FIFO.
REQ-024 issue_ack_in while request_valid_out = 0 SHALL be ignored (no pointer or count change).
REQ-025 request_valid_in while full SHALL leave state unchanged; upstream holds the word until acked.
REQ-026 Simultaneous push and pop at count 1 SHALL keep count 1 with the new word at head after the edge.
REQ-027 request_out and request_valid_out SHALL be stable while request_valid_out = 1 and issue_ack_in = 0.

Reset
REQ-028 While reset_in = 0 at an edge: pointers = 0, count = 0, request_valid_out = 0, request_out = 0, empty_out = 1, full_out = 0, issue_ack_out = 0 during reset cycles.
REQ-029 Reset mid-operation SHALL discard all entries; storage array contents need not be cleared.
REQ-030 First push SHALL be accepted on the first edge after reset_in returns to 1.

Verification
REQ-031 Push 0xA1, 0xA2, 0xA3 with issue_ack_in = 0 -> count 3, request_out = 0xA1, request_valid_out = 1 held stable.
REQ-032 Fill to 8 with issue_ack_in = 0, request_valid_in held 1 -> full_out = 1, issue_ack_out = 0, 9th word not stored, count 8.
REQ-033 Full queue, issue_ack_in = 1 and request_valid_in = 1 same cycle -> one pop, no push, count 7; push accepted next cycle, count back to 8.
REQ-034 Continuous push/pop of 20 words 0x00..0x13 -> output order 0x00..0x13 across two pointer wraps, no gaps or repeats.
REQ-035 Count 1, simultaneous push 0xB2 and pop of 0xB1 -> count 1, request_out = 0xB2 after the edge.
REQ-036 reset_in = 0 for one edge with count 5 -> count 0, request_valid_out = 0, request_out = 0; issue_ack_in pulse on empty queue causes no change.
